// File: rtl/grf_multiport_if.sv
// grf_multiport_if: port bundle for the multi-port general register file.
//
// Signal groups (all sampled on the rising edge of the owning block's clock):
//   read A   : ra (addr)            -> da, busy_a
//   read B   : rb (addr)            -> db, busy_b
//   write 0  : we0, wa0, wd0        (ALU / late writeback, younger instruction)
//   write 1  : we1, wa1, wd1        (load writeback, older instruction)
//   issue    : iss, iss_rd          (decode marks a destination busy)
//   status   : busy_cnt             (number of busy registers, registered)
//
// Strobe semantics: there is no valid/ready back-pressure on this block.
// A write or issue is accepted on every rising edge where its enable is high
// (except during reset); the register file can never refuse it. Read data
// and busy flags are combinational and valid whenever the address is stable.
//
// Modports: master = pipeline side (drives addresses/strobes),
//           slave  = register file.
interface grf_multiport_if #(
  parameter int DW = 32,
  parameter int AW = 5
);
  logic [AW-1:0] ra;
  logic [AW-1:0] rb;
  logic [DW-1:0] da;
  logic [DW-1:0] db;
  logic          we0;
  logic [AW-1:0] wa0;
  logic [DW-1:0] wd0;
  logic          we1;
  logic [AW-1:0] wa1;
  logic [DW-1:0] wd1;
  logic          iss;
  logic [AW-1:0] iss_rd;
  logic          busy_a;
  logic          busy_b;
  logic [AW:0]   busy_cnt;

  modport master (
    output ra, rb, we0, wa0, wd0, we1, wa1, wd1, iss, iss_rd,
    input  da, db, busy_a, busy_b, busy_cnt
  );

  modport slave (
    input  ra, rb, we0, wa0, wd0, we1, wa1, wd1, iss, iss_rd,
    output da, db, busy_a, busy_b, busy_cnt
  );
endinterface

// File: rtl/grf_multiport.sv
// grf_multiport: 2-read / 2-write general register file with same-cycle
// write-to-read bypass and a per-register pending-write scoreboard.
//
// Ports:
//   clk    in  clock, all state updates on the rising edge
//   reset  in  synchronous active-high reset
//   bus    grf_multiport_if.slave (read ports A/B, write ports 0/1,
//          issue strobe, busy flags, busy count)
//
// Register 0 reads as zero and is never written or marked busy.
// Reset values: GP_IDX = GP_INIT, SP_IDX = SP_INIT, all others 0; the
// same values are present from time zero.
//
// Optional build macro GRF_TRACE_EN: when defined, every committed write
// prints "@t: $rr <= hhhhhhhh", and a port-1 write that loses a collision
// prints "@t: $rr port1 write dropped". Without it no display code exists.
module grf_multiport #(
  parameter int            DW      = 32,
  parameter int            AW      = 5,
  parameter int            GP_IDX  = 28,
  parameter logic [DW-1:0] GP_INIT = 32'h0000_1800,
  parameter int            SP_IDX  = 29,
  parameter logic [DW-1:0] SP_INIT = 32'h0000_2ffc
) (
  input logic              clk,
  input logic              reset,
  grf_multiport_if.slave   bus
);
  localparam int NREG = 2 ** AW;

  typedef logic [DW-1:0] regFile_t [NREG];

  function automatic regFile_t resetImage();
    regFile_t img;
    for (int i = 0; i < NREG; i++) img[i] = '0;
    img[GP_IDX] = GP_INIT;
    img[SP_IDX] = SP_INIT;
    return img;
  endfunction

  regFile_t        regs    = resetImage();
  logic [NREG-1:0] busy    = '0;
  logic [AW:0]     busyCnt = '0;

  // Committed writes. Port 0 carries the younger instruction, so on an
  // address collision the port-1 write is suppressed.
  logic wr0, wr1, collide;
  assign wr0     = bus.we0 && (bus.wa0 != '0);
  assign collide = wr0 && bus.we1 && (bus.wa1 == bus.wa0);
  assign wr1     = bus.we1 && (bus.wa1 != '0) && !collide;

  // Read bypass hits, port 0 first.
  logic hit0a, hit1a, hit0b, hit1b;
  assign hit0a = bus.we0 && (bus.wa0 == bus.ra);
  assign hit1a = bus.we1 && (bus.wa1 == bus.ra);
  assign hit0b = bus.we0 && (bus.wa0 == bus.rb);
  assign hit1b = bus.we1 && (bus.wa1 == bus.rb);

  always_comb begin
    if (bus.ra == '0)  bus.da = '0;
    else if (hit0a)    bus.da = bus.wd0;
    else if (hit1a)    bus.da = bus.wd1;
    else               bus.da = regs[bus.ra];
  end

  always_comb begin
    if (bus.rb == '0)  bus.db = '0;
    else if (hit0b)    bus.db = bus.wd0;
    else if (hit1b)    bus.db = bus.wd1;
    else               bus.db = regs[bus.rb];
  end

  // A register whose value is on a write port this cycle is already
  // available through the bypass, so it is not reported busy.
  assign bus.busy_a   = busy[bus.ra] && !(hit0a || hit1a);
  assign bus.busy_b   = busy[bus.rb] && !(hit0b || hit1b);
  assign bus.busy_cnt = busyCnt;

  // Scoreboard next state: writes clear, issue sets; set is applied last
  // so a new issue wins over a retiring write to the same register.
  logic            setEn;
  logic [NREG-1:0] busyNext;
  assign setEn = bus.iss && (bus.iss_rd != '0);

  always_comb begin
    busyNext = busy;
    if (wr0) busyNext[bus.wa0] = 1'b0;
    if (wr1) busyNext[bus.wa1] = 1'b0;
    if (setEn) busyNext[bus.iss_rd] = 1'b1;
  end

  // Incremental count: +1 when a clear bit is set, -1 for each busy bit
  // that is actually cleared (and not re-set by a coincident issue).
  // wr1 already excludes a collision, so one register is never counted twice.
  logic setNew, clr0, clr1;
  assign setNew = setEn && !busy[bus.iss_rd];
  assign clr0   = wr0 && busy[bus.wa0] && !(setEn && (bus.iss_rd == bus.wa0));
  assign clr1   = wr1 && busy[bus.wa1] && !(setEn && (bus.iss_rd == bus.wa1));

  always_ff @(posedge clk) begin
    if (reset) begin
      regs    <= resetImage();
      busy    <= '0;
      busyCnt <= '0;
    end else begin
      if (wr1) regs[bus.wa1] <= bus.wd1;
      if (wr0) regs[bus.wa0] <= bus.wd0;
      busy    <= busyNext;
      busyCnt <= busyCnt + (AW+1)'(setNew) - (AW+1)'(clr0) - (AW+1)'(clr1);
`ifdef GRF_TRACE_EN
      if (wr0) $display("@%0t: $%02d <= %08h", $time, bus.wa0, bus.wd0);
      if (wr1) $display("@%0t: $%02d <= %08h", $time, bus.wa1, bus.wd1);
      if (collide) $display("@%0t: $%02d port1 write dropped", $time, bus.wa1);
`endif
    end
  end
endmodule
